// File: rtl/perf_event_counter_bank_pkg.sv
// Shared types and helpers for the performance event counter bank.
package perf_event_counter_bank_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFrozen = 2'd2
  } state_e;

  // Select width covering NumCh event channels plus the cycle counter.
  function automatic int unsigned sel_w(int unsigned num_ch);
    return $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/perf_event_counter_bank_if.sv
// Control, event and read-port signals of the counter bank.
interface perf_event_counter_bank_if #(
  parameter int unsigned NumCh = 4,
  parameter int unsigned CntW  = 32
);
  localparam int unsigned SelW = perf_event_counter_bank_pkg::sel_w(NumCh);

  logic             clr;
  logic             start;
  logic             halt;
  logic [NumCh-1:0] event_in;
  logic             rd_req;
  logic [SelW-1:0]  rd_sel;
  logic             rd_valid;
  logic [CntW-1:0]  rd_data;
  logic             rd_ovf;
  logic             rd_err;
  logic             running;
  logic             frozen;

  modport master (
    output clr, start, halt, event_in, rd_req, rd_sel,
    input  rd_valid, rd_data, rd_ovf, rd_err, running, frozen
  );

  modport slave (
    input  clr, start, halt, event_in, rd_req, rd_sel,
    output rd_valid, rd_data, rd_ovf, rd_err, running, frozen
  );

endinterface

// File: rtl/perf_event_counter_bank_ctr_cell.sv
// One event counter with a sticky overflow bit; saturates or wraps at all-ones.
module perf_event_counter_bank_ctr_cell #(
  parameter int unsigned CntW = 32,
  parameter bit          Sat  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            inc_i,
  output logic [CntW-1:0] cnt_o,
  output logic            ovf_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i && inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = Sat ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_event_counter_bank.sv
// Bank of NumCh event counters plus a cycle counter, gated by an IDLE/RUN/FROZEN FSM,
// with a registered one-cycle-latency read port.
module perf_event_counter_bank
  import perf_event_counter_bank_pkg::*;
#(
  parameter int unsigned NumCh = 4,
  parameter int unsigned CntW  = 32,
  parameter bit          Sat   = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  perf_event_counter_bank_if.slave      bus
);

  localparam int unsigned SelW   = sel_w(NumCh);
  localparam int unsigned NumCtr = NumCh + 1;

  state_e              state_q, state_d;
  logic                count_en;
  logic [NumCtr-1:0]   inc;
  logic [CntW-1:0]     cnt [NumCtr];
  logic [NumCtr-1:0]   ovf;

  logic [CntW-1:0]     sel_data;
  logic                sel_ovf, sel_err;
  logic                rd_valid_q, rd_ovf_q, rd_err_q;
  logic [CntW-1:0]     rd_data_q;

  // clr wins over halt, halt over start.
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (bus.start) state_d = StRun;
        StRun:    if (bus.halt)  state_d = StFrozen;
        StFrozen: state_d = StFrozen;
        default:  state_d = StIdle;
      endcase
    end
  end

  assign count_en = (state_q == StRun);
  // Top counter is the cycle counter: always incrementing while enabled.
  assign inc      = {1'b1, bus.event_in};

  for (genvar i = 0; i < NumCtr; i++) begin : g_ctr
    perf_event_counter_bank_ctr_cell #(
      .CntW (CntW),
      .Sat  (Sat)
    ) u_cell (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (bus.clr),
      .en_i   (count_en),
      .inc_i  (inc[i]),
      .cnt_o  (cnt[i]),
      .ovf_o  (ovf[i])
    );
  end

  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    sel_err  = 1'b1;
    for (int unsigned i = 0; i < NumCtr; i++) begin
      if (bus.rd_sel == SelW'(i)) begin
        sel_data = cnt[i];
        sel_ovf  = ovf[i];
        sel_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        rd_data_q <= sel_data;
        rd_ovf_q  <= sel_ovf;
        rd_err_q  <= sel_err;
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_ovf   = rd_ovf_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.running  = (state_q == StRun);
  assign bus.frozen   = (state_q == StFrozen);

endmodule

// File: tb/tb_perf_event_counter_bank.sv
// Self-checking bench: a saturating and a wrapping 8-bit bank driven in lockstep.
module tb_perf_event_counter_bank;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;

  typedef struct {
    logic [CW-1:0] data;
    logic          ovf;
    logic          err;
  } exp_t;

  typedef struct {
    logic           start;
    logic           halt;
    logic [NCH-1:0] ev;
    logic           run;
    logic           frz;
  } step_vec_t;

  typedef struct {
    logic [2:0]    sel;
    logic [CW-1:0] data;
    logic          err;
  } rd_vec_t;

  logic clk;
  logic rst_ni;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t qa[$];
  exp_t qb[$];

  perf_event_counter_bank_if #(.NumCh(NCH), .CntW(CW)) ia ();
  perf_event_counter_bank_if #(.NumCh(NCH), .CntW(CW)) ib ();

  assign ib.clr      = ia.clr;
  assign ib.start    = ia.start;
  assign ib.halt     = ia.halt;
  assign ib.event_in = ia.event_in;
  assign ib.rd_req   = ia.rd_req;
  assign ib.rd_sel   = ia.rd_sel;

  perf_event_counter_bank #(.NumCh(NCH), .CntW(CW), .Sat(1'b1)) u_dut_sat (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (ia)
  );

  perf_event_counter_bank #(.NumCh(NCH), .CntW(CW), .Sat(1'b0)) u_dut_wrap (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [2:0] sel, input logic [CW-1:0] da, input logic [CW-1:0] db,
                    input logic oa, input logic ob, input logic err);
    exp_t e;
    ia.rd_req = 1'b1;
    ia.rd_sel = sel;
    e.data = da; e.ovf = oa; e.err = err; qa.push_back(e);
    e.data = db; e.ovf = ob; e.err = err; qb.push_back(e);
    cyc(1);
    ia.rd_req = 1'b0;
  endtask

  // Scoreboard: each read result is matched against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (ia.rd_valid) begin
      if (qa.size() == 0) chk("valid_a_unexpected", 32'(ia.rd_valid), 32'd0);
      else begin
        e = qa.pop_front();
        chk("rd_data_a", 32'(ia.rd_data), 32'(e.data));
        chk("rd_ovf_a", 32'(ia.rd_ovf), 32'(e.ovf));
        chk("rd_err_a", 32'(ia.rd_err), 32'(e.err));
      end
    end
    if (ib.rd_valid) begin
      if (qb.size() == 0) chk("valid_b_unexpected", 32'(ib.rd_valid), 32'd0);
      else begin
        e = qb.pop_front();
        chk("rd_data_b", 32'(ib.rd_data), 32'(e.data));
        chk("rd_ovf_b", 32'(ib.rd_ovf), 32'(e.ovf));
        chk("rd_err_b", 32'(ib.rd_err), 32'(e.err));
      end
    end
  end

  initial begin
    step_vec_t steps [10];
    rd_vec_t   rds [7];

    // Start cycle, 7 plain RUN cycles, halt cycle, then start while frozen.
    steps[0] = '{1'b1, 1'b0, 4'b0001, 1'b1, 1'b0};
    steps[1] = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b0};
    steps[2] = '{1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};
    steps[3] = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b0};
    steps[4] = '{1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};
    steps[5] = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b0};
    steps[6] = '{1'b0, 1'b0, 4'b0001, 1'b1, 1'b0};
    steps[7] = '{1'b0, 1'b0, 4'b0101, 1'b1, 1'b0};
    steps[8] = '{1'b0, 1'b1, 4'b0001, 1'b0, 1'b1};
    steps[9] = '{1'b1, 1'b0, 4'b1111, 1'b0, 1'b1};
    rds[0] = '{3'd0, 8'd8, 1'b0};
    rds[1] = '{3'd1, 8'd0, 1'b0};
    rds[2] = '{3'd2, 8'd4, 1'b0};
    rds[3] = '{3'd3, 8'd0, 1'b0};
    rds[4] = '{3'd4, 8'd8, 1'b0};
    rds[5] = '{3'd7, 8'd0, 1'b1};
    rds[6] = '{3'd5, 8'd0, 1'b1};

    rst_ni = 1'b0;
    ia.clr = 1'b0; ia.start = 1'b0; ia.halt = 1'b0;
    ia.event_in = '0; ia.rd_req = 1'b0; ia.rd_sel = '0;

    // T1: reset values, then events while idle are ignored.
    cyc(2);
    chk("rst_rd_valid", 32'(ia.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(ia.rd_data), 32'd0);
    chk("rst_running", 32'(ia.running), 32'd0);
    chk("rst_frozen", 32'(ia.frozen), 32'd0);
    chk("rst_rd_ovf", 32'(ia.rd_ovf), 32'd0);
    rst_ni = 1'b1;
    ia.event_in = 4'b1111;
    cyc(10);
    for (int s = 0; s <= int'(NCH); s++) rd(3'(s), 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    ia.event_in = '0;
    cyc(1);

    // T2: table-driven counting sequence, then read-back table (includes bad selects).
    for (int i = 0; i < 10; i++) begin
      ia.start = steps[i].start;
      ia.halt = steps[i].halt;
      ia.event_in = steps[i].ev;
      cyc(1);
      chk($sformatf("t2_running[%0d]", i), 32'(ia.running), 32'(steps[i].run));
      chk($sformatf("t2_frozen[%0d]", i), 32'(ia.frozen), 32'(steps[i].frz));
    end
    ia.start = 1'b0; ia.halt = 1'b0; ia.event_in = '0;
    for (int i = 0; i < 7; i++) rd(rds[i].sel, rds[i].data, rds[i].data, 1'b0, 1'b0, rds[i].err);
    cyc(1);

    // T4: back-to-back reads of the cycle counter while running.
    ia.clr = 1'b1;
    cyc(1);
    ia.clr = 1'b0;
    chk("clr_frozen", 32'(ia.frozen), 32'd0);
    ia.event_in = 4'b0010;
    ia.start = 1'b1;
    cyc(1);
    ia.start = 1'b0;
    for (int k = 0; k < 5; k++) rd(3'd4, 8'(k), 8'(k), 1'b0, 1'b0, 1'b0);
    cyc(1);
    chk("t4_valid_drop", 32'(ia.rd_valid), 32'd0);
    chk("t4_data_hold", 32'(ia.rd_data), 32'd4);
    rd(3'd1, 8'd6, 8'd6, 1'b0, 1'b0, 1'b0);

    // T5: clr + halt + start together while running.
    ia.clr = 1'b1; ia.halt = 1'b1; ia.start = 1'b1;
    cyc(1);
    ia.clr = 1'b0; ia.halt = 1'b0; ia.start = 1'b0; ia.event_in = '0;
    chk("t5_running", 32'(ia.running), 32'd0);
    chk("t5_frozen", 32'(ia.frozen), 32'd0);
    rd(3'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    rd(3'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    ia.halt = 1'b1;
    cyc(1);
    ia.halt = 1'b0;
    chk("t5_halt_idle_frozen", 32'(ia.frozen), 32'd0);

    // T3: 300 events on an 8-bit counter: saturate vs wrap, sticky overflow.
    ia.start = 1'b1;
    cyc(1);
    ia.start = 1'b0;
    ia.event_in = 4'b0001;
    cyc(299);
    ia.halt = 1'b1;
    cyc(1);
    ia.halt = 1'b0; ia.event_in = '0;
    chk("t3_frozen", 32'(ia.frozen), 32'd1);
    rd(3'd0, 8'd255, 8'd44, 1'b1, 1'b1, 1'b0);
    rd(3'd4, 8'd255, 8'd44, 1'b1, 1'b1, 1'b0);
    rd(3'd3, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(1);

    // T6: asynchronous reset in the middle of a run.
    ia.clr = 1'b1;
    cyc(1);
    ia.clr = 1'b0; ia.start = 1'b1;
    cyc(1);
    ia.start = 1'b0; ia.event_in = 4'b1111;
    cyc(3);
    rd(3'd4, 8'd3, 8'd3, 1'b0, 1'b0, 1'b0);
    cyc(1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_rd_data", 32'(ia.rd_data), 32'd0);
    chk("t6_rst_rd_valid", 32'(ia.rd_valid), 32'd0);
    chk("t6_rst_running", 32'(ia.running), 32'd0);
    chk("t6_rst_wrap_data", 32'(ib.rd_data), 32'd0);
    cyc(2);
    rst_ni = 1'b1;
    ia.event_in = '0;
    for (int s = 0; s <= int'(NCH); s++) rd(3'(s), 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(2);

    chk("queue_a_drained", 32'(qa.size()), 32'd0);
    chk("queue_b_drained", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
